dcache_sram_sched: RTL and testbench

//  Schedules the shared dcache SRAM port (data/tag/valid-dirty arrays) among the

---
 rtl/std_cache_pkg.sv | 23 ++
 rtl/dcache_rr_pick.sv | 50 +++++
 rtl/dcache_sram_sched_chk.sv | 31 +++
 rtl/dcache_sram_sched.sv | 192 +++++++++++++++++++
 tb/tb_dcache_sram_sched.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/std_cache_pkg.sv
// Shared definitions for the dcache SRAM port scheduler.
//  DCACHE_NR_SRAM_PORTS : default number of requesters on the shared SRAM port
//  SRAM_PORT_MISS       : port index reserved for the miss handler
//  sram_port_idx_t      : port index type for the default configuration
//  rr_next()            : round-robin pointer advance over ports 1..nr_ports-1
package std_cache_pkg;

    localparam int unsigned DCACHE_NR_SRAM_PORTS = 4;
    localparam int unsigned SRAM_PORT_MISS       = 0;

    typedef logic [$clog2(DCACHE_NR_SRAM_PORTS)-1:0] sram_port_idx_t;

    // Pointer after a grant to port idx; port 0 never takes part in round-robin,
    // so the pointer wraps from the last port back to 1.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nr_ports);
        if (idx >= nr_ports - 1) begin
            return 1;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/dcache_rr_pick.sv
// Combinational first-set finder starting from a pointer.
//  vec_i   : candidate vector
//  ptr_i   : search start index (search wraps to index 0 after WIDTH-1)
//  found_o : any bit of vec_i set
//  idx_o   : first set index at/after ptr_i, else lowest set index (0 when none)
module dcache_rr_pick #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [WIDTH-1:0] hi_vec_s;

    // Lowest set bit of a vector; descending scan so the lowest index wins.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Keep only candidates at or after the pointer.
    always_comb begin
        hi_vec_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            hi_vec_s[i] = vec_i[i] & (i >= int'(ptr_i));
        end
    end

    // Prefer the upper segment; fall back to the wrapped search from index 0.
    always_comb begin
        found_o = |vec_i;
        if (|hi_vec_s) begin
            idx_o = lowest_set(hi_vec_s);
        end else begin
            idx_o = lowest_set(vec_i);
        end
    end

endmodule

// File: rtl/dcache_sram_sched_chk.sv
// Protocol checker for dcache_sram_sched.
//  req_i/gnt_i       : scheduler request and grant vectors
//  lock_q_i/owner_q_i: lock state and lock owner of the scheduler
module dcache_sram_sched_chk #(
    parameter int unsigned NR_PORTS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic [NR_PORTS-1:0] req_i,
    input logic [NR_PORTS-1:0] gnt_i,
    input logic                lock_q_i,
    input logic [IDX_W-1:0]    owner_q_i
);

    logic [NR_PORTS-1:0] req_q_r;

    // Previous-cycle requests, to relate a held lock to the request that created it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q_r <= {NR_PORTS{1'b0}};
        end else begin
            req_q_r <= req_i;
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_i));
    a_gnt_subset:  assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_i & ~req_i) == {NR_PORTS{1'b0}});
    a_lock_has_req: assert property (@(posedge clk_i) disable iff (!rst_ni) lock_q_i |-> req_q_r[owner_q_i]);

endmodule

// File: rtl/dcache_sram_sched.sv
// Scheduler for the shared dcache SRAM port (data/tag/valid-dirty arrays).
//  clk_i/rst_ni : clock, async active-low reset
//  req_i        : per-port request (port 0 = miss handler)
//  we_i         : request is a write (no read data returned)
//  lock_i       : keep the grant next cycle (RMW sequence), meaningful with req_i
//  gnt_o        : one-hot grant, combinational
//  sel_o        : index of the granted port (0 when none)
//  rvalid_o     : read data for last cycle's grant is valid now
//  rowner_o     : port owning the rvalid_o data
//  starve_o     : this cycle's grant was forced by the wait guard
// Priority: held lock > aged port (lowest index) > miss handler > round-robin 1..N-1.
module dcache_sram_sched
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS = DCACHE_NR_SRAM_PORTS,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned LOCK_MAX = 16,
    localparam int unsigned IDX_W   = $clog2(NR_PORTS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [NR_PORTS-1:0] we_i,
    input  logic [NR_PORTS-1:0] lock_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]    sel_o,
    output logic                rvalid_o,
    output logic [IDX_W-1:0]    rowner_o,
    output logic                starve_o
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int unsigned LCNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

    logic [IDX_W-1:0]    rr_ptr_r, owner_r, rowner_r;
    logic [WAIT_W-1:0]   wait_cnt_r [1:NR_PORTS-1];
    logic                lock_r, rvalid_r;
    logic [LCNT_W-1:0]   lock_cnt_r;

    logic [NR_PORTS-1:0] rr_vec_s, starve_vec_s, gnt_s;
    logic                lock_hit_s, starve_found_s, rr_found_s, adv_s, starve_s, any_gnt_s;
    logic [IDX_W-1:0]    starve_idx_s, rr_idx_s, sel_s;
    logic [IDX_W-1:0]    rr_ptr_n_s, owner_n_s, rowner_n_s;
    logic [WAIT_W-1:0]   wait_cnt_n_s [1:NR_PORTS-1];
    logic                lock_n_s, rvalid_n_s;
    logic [LCNT_W-1:0]   lock_cnt_n_s;

    // Candidate vectors: port 0 never ages and never joins round-robin.
    always_comb begin
        starve_vec_s = {NR_PORTS{1'b0}};
        rr_vec_s     = req_i;
        rr_vec_s[0]  = 1'b0;
        for (int k = 1; k < NR_PORTS; k++) begin
            starve_vec_s[k] = req_i[k] & (wait_cnt_r[k] == WAIT_W'(MAX_WAIT));
        end
    end

    assign lock_hit_s = lock_r & req_i[owner_r];

    dcache_rr_pick #(.WIDTH(NR_PORTS)) u_starve_pick (
        .vec_i   (starve_vec_s),
        .ptr_i   (IDX_W'(1)),
        .found_o (starve_found_s),
        .idx_o   (starve_idx_s)
    );

    dcache_rr_pick #(.WIDTH(NR_PORTS)) u_rr_pick (
        .vec_i   (rr_vec_s),
        .ptr_i   (rr_ptr_r),
        .found_o (rr_found_s),
        .idx_o   (rr_idx_s)
    );

    // Priority mux selecting the single winner of this cycle.
    always_comb begin
        gnt_s    = {NR_PORTS{1'b0}};
        sel_s    = {IDX_W{1'b0}};
        starve_s = 1'b0;
        adv_s    = 1'b0;
        if (lock_hit_s) begin
            sel_s = owner_r;
        end else if (starve_found_s) begin
            sel_s    = starve_idx_s;
            starve_s = 1'b1;
            adv_s    = 1'b1;
        end else if (req_i[SRAM_PORT_MISS]) begin
            sel_s = IDX_W'(SRAM_PORT_MISS);
        end else if (rr_found_s) begin
            sel_s = rr_idx_s;
            adv_s = 1'b1;
        end else begin
            sel_s = {IDX_W{1'b0}};
        end
        any_gnt_s = lock_hit_s | starve_found_s | req_i[SRAM_PORT_MISS] | rr_found_s;
        if (any_gnt_s) begin
            gnt_s[sel_s] = 1'b1;
        end else begin
            gnt_s = {NR_PORTS{1'b0}};
        end
    end

    // Next-state for pointer, wait counters, read tracking and lock.
    always_comb begin
        if (adv_s) begin
            rr_ptr_n_s = IDX_W'(rr_next(int'(sel_s), NR_PORTS));
        end else begin
            rr_ptr_n_s = rr_ptr_r;
        end

        // Aging runs during locked cycles too, so a long RMW still raises starvation.
        for (int k = 1; k < NR_PORTS; k++) begin
            if (req_i[k] && !gnt_s[k]) begin
                if (wait_cnt_r[k] == WAIT_W'(MAX_WAIT)) begin
                    wait_cnt_n_s[k] = wait_cnt_r[k];
                end else begin
                    wait_cnt_n_s[k] = wait_cnt_r[k] + WAIT_W'(1);
                end
            end else begin
                wait_cnt_n_s[k] = {WAIT_W{1'b0}};
            end
        end

        rvalid_n_s = any_gnt_s & ~we_i[sel_s];
        if (any_gnt_s) begin
            rowner_n_s = sel_s;
        end else begin
            rowner_n_s = rowner_r;
        end

        // A locked run, counting the grant that set it, lasts at most LOCK_MAX grants.
        owner_n_s    = owner_r;
        lock_n_s     = 1'b0;
        lock_cnt_n_s = {LCNT_W{1'b0}};
        if (lock_hit_s) begin
            if (!lock_i[owner_r] || (int'(lock_cnt_r) + 1 >= int'(LOCK_MAX) - 1)) begin
                lock_n_s     = 1'b0;
                lock_cnt_n_s = {LCNT_W{1'b0}};
            end else begin
                lock_n_s     = 1'b1;
                lock_cnt_n_s = lock_cnt_r + LCNT_W'(1);
            end
        end else if (any_gnt_s && lock_i[sel_s]) begin
            lock_n_s     = 1'b1;
            owner_n_s    = sel_s;
            lock_cnt_n_s = {LCNT_W{1'b0}};
        end else begin
            lock_n_s     = 1'b0;
            lock_cnt_n_s = {LCNT_W{1'b0}};
        end
    end

    // Scheduler state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r   <= IDX_W'(1);
            owner_r    <= {IDX_W{1'b0}};
            lock_r     <= 1'b0;
            lock_cnt_r <= {LCNT_W{1'b0}};
            rvalid_r   <= 1'b0;
            rowner_r   <= {IDX_W{1'b0}};
            for (int k = 1; k < NR_PORTS; k++) begin
                wait_cnt_r[k] <= {WAIT_W{1'b0}};
            end
        end else begin
            rr_ptr_r   <= rr_ptr_n_s;
            owner_r    <= owner_n_s;
            lock_r     <= lock_n_s;
            lock_cnt_r <= lock_cnt_n_s;
            rvalid_r   <= rvalid_n_s;
            rowner_r   <= rowner_n_s;
            for (int k = 1; k < NR_PORTS; k++) begin
                wait_cnt_r[k] <= wait_cnt_n_s[k];
            end
        end
    end

    assign gnt_o    = gnt_s;
    assign sel_o    = sel_s;
    assign starve_o = starve_s;
    assign rvalid_o = rvalid_r;
    assign rowner_o = rowner_r;

    dcache_sram_sched_chk #(.NR_PORTS(NR_PORTS), .IDX_W(IDX_W)) u_chk (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .gnt_i     (gnt_s),
        .lock_q_i  (lock_r),
        .owner_q_i (owner_r)
    );

endmodule

// File: tb/tb_dcache_sram_sched.sv
// Directed scoreboard bench for dcache_sram_sched (NR_PORTS=4, MAX_WAIT=8, LOCK_MAX=16).
module tb_dcache_sram_sched;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] req_i, we_i, lock_i, gnt_o;
    logic [1:0] sel_o, rowner_o;
    logic       rvalid_o, starve_o;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       starve;
        logic       rvalid;
        logic [1:0] rowner;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;

    dcache_sram_sched #(.NR_PORTS(4), .MAX_WAIT(8), .LOCK_MAX(16)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .lock_i   (lock_i),
        .gnt_o    (gnt_o),
        .sel_o    (sel_o),
        .rvalid_o (rvalid_o),
        .rowner_o (rowner_o),
        .starve_o (starve_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [3:0] g, input logic st, input logic rv, input logic [1:0] ro);
        exp_t e;
        e.gnt = g; e.sel = enc(g); e.starve = st; e.rvalid = rv; e.rowner = ro;
        return e;
    endfunction

    // Drive one cycle of inputs (called just after a posedge) and queue its expectation.
    task automatic apply(input logic [3:0] req, input logic [3:0] we, input logic [3:0] lock,
                         input logic [3:0] egnt, input logic est, input logic erv, input logic [1:0] ero);
        req_i = req; we_i = we; lock_i = lock;
        exp_q.push_back(mk(egnt, est, erv, ero));
        @(posedge clk_i); #1;
    endtask

    // Monitor: compare DUT outputs against the oldest expectation on every falling edge.
    initial begin
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                n_vec++;
                if (gnt_o !== cur.gnt) begin
                    n_err++; $display("FAIL gnt vec%0d: got %b want %b", n_vec, gnt_o, cur.gnt);
                end
                if (sel_o !== cur.sel) begin
                    n_err++; $display("FAIL sel vec%0d: got %0d want %0d", n_vec, sel_o, cur.sel);
                end
                if (starve_o !== cur.starve) begin
                    n_err++; $display("FAIL starve vec%0d: got %b want %b", n_vec, starve_o, cur.starve);
                end
                if (rvalid_o !== cur.rvalid) begin
                    n_err++; $display("FAIL rvalid vec%0d: got %b want %b", n_vec, rvalid_o, cur.rvalid);
                end
                if (rowner_o !== cur.rowner) begin
                    n_err++; $display("FAIL rowner vec%0d: got %0d want %0d", n_vec, rowner_o, cur.rowner);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; req_i = 4'b0000; we_i = 4'b0000; lock_i = 4'b0000;
        repeat (2) @(posedge clk_i);
        #1; rst_ni = 1'b1;

        // Reset state, then round-robin sweep 1->2->3 and pointer back at 1.
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
        apply(4'b1110, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd0);
        apply(4'b1110, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd1);
        apply(4'b1110, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 2'd2);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3);
        apply(4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd3);

        // Port 1 ages behind port 0 and is forced on the 9th cycle.
        apply(4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 7; i++) apply(4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0);
        apply(4'b0011, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd0);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd1);

        // Two ports starve together: lowest first, the other on the next cycle.
        apply(4'b0111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd1);
        for (int i = 0; i < 7; i++) apply(4'b0111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd0);
        apply(4'b0111, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd0);
        apply(4'b0111, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd1);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);

        // Port 2 lock holds off port 0 for three grants.
        apply(4'b0100, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0, 2'd2);
        apply(4'b0101, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2);
        apply(4'b0101, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b1, 2'd2);
        apply(4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 2'd2);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0);

        // Port 3 lock held: 16 grants, then starved port 1 wins, then port 3 again.
        apply(4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 2'd0);
        for (int i = 0; i < 15; i++) apply(4'b1010, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 2'd3);
        apply(4'b1010, 4'b0000, 4'b1000, 4'b0010, 1'b1, 1'b1, 2'd3);
        apply(4'b1010, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 2'd1);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd3);

        // Read grant then write grant: one rvalid, owner follows the write grant.
        apply(4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 2'd3);
        apply(4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 2'd1);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2);

        // Async reset while port 3 holds a lock.
        apply(4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0, 2'd2);
        apply(4'b1100, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b1, 2'd3);
        rst_ni = 1'b0; req_i = 4'b1100; we_i = 4'b0000; lock_i = 4'b1000;
        exp_q.push_back(mk(4'b0100, 1'b0, 1'b0, 2'd0));
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        apply(4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 2'd0);
        apply(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd2);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk_i);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
